// File: rtl/game_pkg.sv
// Shared sprite/game definitions: animation types and sprite ROM geometry.
package game_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Run  = 2'd1,
    Jump = 2'd2,
    Fall = 2'd3
  } anim_type_enum;

  localparam int unsigned SPRITE_W    = 32;
  localparam int unsigned SPRITE_H    = 48;
  localparam int unsigned FRAME_WORDS = SPRITE_W * SPRITE_H;

endpackage

// File: rtl/rising_edge_detect.sv
// Registers a level on Clk and emits a one-cycle pulse on each low-to-high sample.
module rising_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/sprite_anim_controller.sv
// Per-player animation sequencer: picks Idle/Run/Jump/Fall on each frame tick,
// steps the frame index at a fixed hold rate and registers the sprite ROM base address.
module sprite_anim_controller
  import game_pkg::*;
#(
  parameter int unsigned IDLE_FRAMES = 4,
  parameter int unsigned RUN_FRAMES  = 4,
  parameter int unsigned JUMP_FRAMES = 2,
  parameter int unsigned FALL_FRAMES = 2,
  parameter int unsigned HOLD_TICKS  = 3,
  parameter int unsigned FRAME_WORDS = game_pkg::FRAME_WORDS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        revive,
  input  logic        pause,
  input  logic [9:0]  x_motion,
  input  logic [9:0]  y_motion,
  input  logic        on_ground,
  output logic [1:0]  anim_type,
  output logic [2:0]  frame_index,
  output logic        facing_left,
  output logic [14:0] rom_base,
  output logic        frame_tick
);

  localparam int unsigned RunOffset  = IDLE_FRAMES;
  localparam int unsigned JumpOffset = IDLE_FRAMES + RUN_FRAMES;
  localparam int unsigned FallOffset = IDLE_FRAMES + RUN_FRAMES + JUMP_FRAMES;

  logic          clear;
  logic          tick;
  anim_type_enum type_q, type_d, sel_type;
  logic [2:0]    idx_q, idx_d, last_idx;
  logic [3:0]    hold_q, hold_d;
  logic          facing_q, facing_d;
  logic [14:0]   rom_q, rom_d;
  logic          tick_q, tick_d;
  logic [4:0]    slot;

  assign clear = Reset | revive;

  rising_edge_detect u_tick_detect (
    .Clk  (Clk),
    .Reset(clear),
    .in   (frame_clk),
    .pulse(tick)
  );

  always_comb begin
    if (y_motion[9]) begin
      sel_type = Jump;
    end else if ((y_motion != 10'd0) || !on_ground) begin
      sel_type = Fall;
    end else if (x_motion != 10'd0) begin
      sel_type = Run;
    end else begin
      sel_type = Idle;
    end
  end

  always_comb begin
    unique case (type_q)
      Idle:    last_idx = 3'(IDLE_FRAMES - 1);
      Run:     last_idx = 3'(RUN_FRAMES - 1);
      Jump:    last_idx = 3'(JUMP_FRAMES - 1);
      default: last_idx = 3'(FALL_FRAMES - 1);
    endcase
  end

  always_comb begin
    type_d   = type_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    facing_d = facing_q;
    tick_d   = 1'b0;
    if (tick && !pause) begin
      tick_d = 1'b1;
      if (x_motion[9]) begin
        facing_d = 1'b1;
      end else if (x_motion != 10'd0) begin
        facing_d = 1'b0;
      end
      if (sel_type != type_q) begin
        type_d = sel_type;
        idx_d  = 3'd0;
        hold_d = 4'd0;
      end else if (hold_q == 4'(HOLD_TICKS - 1)) begin
        hold_d = 4'd0;
        // Idle/Run loop; Jump/Fall stick on their final frame.
        if (idx_q != last_idx) begin
          idx_d = idx_q + 3'd1;
        end else if ((type_q == Idle) || (type_q == Run)) begin
          idx_d = 3'd0;
        end
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  always_comb begin
    unique case (type_d)
      Idle:    slot = {2'b00, idx_d};
      Run:     slot = 5'(RunOffset) + {2'b00, idx_d};
      Jump:    slot = 5'(JumpOffset) + {2'b00, idx_d};
      default: slot = 5'(FallOffset) + {2'b00, idx_d};
    endcase
    rom_d = 15'(slot * FRAME_WORDS);
  end

  always_ff @(posedge Clk) begin
    if (clear) begin
      type_q   <= Idle;
      idx_q    <= 3'd0;
      hold_q   <= 4'd0;
      facing_q <= 1'b0;
      rom_q    <= 15'd0;
      tick_q   <= 1'b0;
    end else begin
      type_q   <= type_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      facing_q <= facing_d;
      rom_q    <= rom_d;
      tick_q   <= tick_d;
    end
  end

  assign anim_type   = type_q;
  assign frame_index = idx_q;
  assign facing_left = facing_q;
  assign rom_base    = rom_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_sprite_anim_controller.sv
// Directed self-checking bench for sprite_anim_controller with default parameters.
module tb_sprite_anim_controller;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, revive, pause, on_ground;
  logic [9:0]  x_motion, y_motion;
  logic [1:0]  anim_type;
  logic [2:0]  frame_index;
  logic        facing_left;
  logic [14:0] rom_base;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int pulses;

  sprite_anim_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .revive     (revive),
    .pause      (pause),
    .x_motion   (x_motion),
    .y_motion   (y_motion),
    .on_ground  (on_ground),
    .anim_type  (anim_type),
    .frame_index(frame_index),
    .facing_left(facing_left),
    .rom_base   (rom_base),
    .frame_tick (frame_tick)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int unsigned typ, input int unsigned idx,
                         input int unsigned face, input int unsigned rom, input int unsigned tk);
    chk({tag, ".type"}, 32'(anim_type), typ);
    chk({tag, ".idx"}, 32'(frame_index), idx);
    chk({tag, ".face"}, 32'(facing_left), face);
    chk({tag, ".rom"}, 32'(rom_base), rom);
    chk({tag, ".tick"}, 32'(frame_tick), tk);
  endtask

  // Raise frame_clk for one cycle; returns at the negedge after the update edge.
  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; revive = 1'b0; pause = 1'b0; on_ground = 1'b1;
    x_motion = 10'd0; y_motion = 10'd0;
    repeat (3) @(negedge Clk);
    chk_out("reset", 0, 0, 0, 0, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Idle loop: index = (k/3) mod 4 after tick k
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out($sformatf("idle%0d", k), 0, (k / 3) % 4, 0, ((k / 3) % 4) * 1536, 1);
    end
    @(negedge Clk);
    chk("idle.tick_low", 32'(frame_tick), 0);

    x_motion = -10'd2;
    tick();
    chk_out("run_left", 1, 0, 1, 6144, 1);
    x_motion = 10'd0;
    tick();
    chk_out("back_idle", 0, 0, 1, 0, 1);

    y_motion = -10'd8;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_out($sformatf("jump%0d", k), 2, (k >= 4) ? 1 : 0, 1, (k >= 4) ? 13824 : 12288, 1);
    end

    // Revive coinciding with a tick wins
    @(negedge Clk) begin frame_clk = 1'b1; revive = 1'b1; end
    @(negedge Clk) begin frame_clk = 1'b0; revive = 1'b0; end
    chk_out("revive", 0, 0, 0, 0, 0);

    y_motion = 10'd0; on_ground = 1'b0; x_motion = 10'd2;
    tick();
    chk_out("fall", 3, 0, 0, 15360, 1);

    on_ground = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    chk_out("run_f2", 1, 2, 0, 9216, 1);
    tick();  // hold_cnt now 1
    chk_out("run_h1", 1, 2, 0, 9216, 1);

    pause = 1'b1; x_motion = -10'd3;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_out($sformatf("pause%0d", k), 1, 2, 0, 9216, 0);
    end
    pause = 1'b0; x_motion = 10'd2;
    tick();
    chk_out("resume_h2", 1, 2, 0, 9216, 1);
    tick();
    chk_out("resume_adv", 1, 3, 0, 10752, 1);

    // frame_clk held high yields a single tick
    pulses = 0;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      pulses += 32'(frame_tick);
    end
    frame_clk = 1'b0;
    chk("held_high_pulses", 32'(pulses), 1);

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
